// File: rtl/sc_shiftadd_sequencer.sv
// Microcode sequencer for a shift-and-add multiplier on a register-file datapath.
// RegGEN0 accumulates the product, RegGEN1 holds the multiplicand, RegGEN2 the multiplier.
module sc_shiftadd_sequencer #(
    parameter int unsigned DATAWIDTH_DECODER_SELECTION    = 3,
    parameter int unsigned DATAWIDTH_MUX_SELECTION        = 3,
    parameter int unsigned DATAWIDTH_ALU_SELECTION        = 4,
    parameter int unsigned DATAWIDTH_REGSHIFTER_SELECTION = 2,
    parameter int unsigned ITERATIONS                     = 8,
    parameter int unsigned DATAWIDTH_COUNT                = 4
) (
    input  logic                                      SC_SHIFTADD_SEQUENCER_CLOCK_50,
    input  logic                                      SC_SHIFTADD_SEQUENCER_Reset_InLow,
    input  logic                                      SC_SHIFTADD_SEQUENCER_Start_InHigh,
    input  logic                                      SC_SHIFTADD_SEQUENCER_Abort_InHigh,
    input  logic                                      SC_SHIFTADD_SEQUENCER_Zero_InLow,
    input  logic                                      SC_SHIFTADD_SEQUENCER_LSB_In,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_SHIFTADD_SEQUENCER_DecoderSelectionWrite_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_SHIFTADD_SEQUENCER_MUXSelectionBUSA_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_SHIFTADD_SEQUENCER_MUXSelectionBUSB_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_SHIFTADD_SEQUENCER_ALUSelection_Out,
    output logic                                      SC_SHIFTADD_SEQUENCER_RegSHIFTERLoad_OutLow,
    output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_SHIFTADD_SEQUENCER_RegSHIFTERShiftSelection_OutLow,
    output logic                                      SC_SHIFTADD_SEQUENCER_Busy_Out,
    output logic                                      SC_SHIFTADD_SEQUENCER_Done_OutHigh
);

    localparam int unsigned DW_DEC = DATAWIDTH_DECODER_SELECTION;
    localparam int unsigned DW_MUX = DATAWIDTH_MUX_SELECTION;
    localparam int unsigned DW_ALU = DATAWIDTH_ALU_SELECTION;
    localparam int unsigned DW_SH  = DATAWIDTH_REGSHIFTER_SELECTION;
    localparam int unsigned DW_CNT = DATAWIDTH_COUNT;

    localparam logic [DW_CNT-1:0] ITER_CNT = DW_CNT'(ITERATIONS);

    localparam logic [DW_DEC-1:0] DEC_NONE = '1;
    localparam logic [DW_DEC-1:0] DEC_R0   = DW_DEC'(0);
    localparam logic [DW_DEC-1:0] DEC_R1   = DW_DEC'(1);
    localparam logic [DW_DEC-1:0] DEC_R2   = DW_DEC'(2);

    localparam logic [DW_MUX-1:0] MUX_NONE = '1;
    localparam logic [DW_MUX-1:0] MUX_R0   = DW_MUX'(0);
    localparam logic [DW_MUX-1:0] MUX_R1   = DW_MUX'(1);
    localparam logic [DW_MUX-1:0] MUX_R2   = DW_MUX'(2);

    localparam logic [DW_ALU-1:0] ALU_IDLE   = '1;
    localparam logic [DW_ALU-1:0] ALU_PASS_A = DW_ALU'(0);
    localparam logic [DW_ALU-1:0] ALU_XOR    = DW_ALU'(4);
    localparam logic [DW_ALU-1:0] ALU_ADD    = DW_ALU'(8);

    localparam logic [DW_SH-1:0] SH_HOLD  = '1;
    localparam logic [DW_SH-1:0] SH_LEFT  = DW_SH'(1);
    localparam logic [DW_SH-1:0] SH_RIGHT = DW_SH'(2);

    typedef enum logic [4:0] {
        S_IDLE  = 5'd0,
        S_CLR_0 = 5'd1,
        S_CLR_1 = 5'd2,
        S_CLR_2 = 5'd3,
        S_TEST  = 5'd4,
        S_ADD_0 = 5'd5,
        S_ADD_1 = 5'd6,
        S_ADD_2 = 5'd7,
        S_SHL_0 = 5'd8,
        S_SHL_1 = 5'd9,
        S_SHL_2 = 5'd10,
        S_SHL_3 = 5'd11,
        S_SHR_0 = 5'd12,
        S_SHR_1 = 5'd13,
        S_SHR_2 = 5'd14,
        S_SHR_3 = 5'd15,
        S_DONE  = 5'd16
    } state_t;

    state_t            state_q, state_d;
    logic [DW_CNT-1:0] cnt_q, cnt_d;

    // State and iteration counter registers.
    always_ff @(posedge SC_SHIFTADD_SEQUENCER_CLOCK_50 or negedge SC_SHIFTADD_SEQUENCER_Reset_InLow) begin
        if (!SC_SHIFTADD_SEQUENCER_Reset_InLow) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update; abort overrides every transition out of a busy state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (SC_SHIFTADD_SEQUENCER_Start_InHigh) begin
                    state_d = S_CLR_0;
                    cnt_d   = '0;
                end
            end
            S_CLR_0: state_d = S_CLR_1;
            S_CLR_1: state_d = S_CLR_2;
            S_CLR_2: state_d = S_TEST;
            S_TEST: begin
                if (!SC_SHIFTADD_SEQUENCER_Zero_InLow || (cnt_q == ITER_CNT)) begin
                    state_d = S_DONE;
                end else if (SC_SHIFTADD_SEQUENCER_LSB_In) begin
                    state_d = S_ADD_0;
                end else begin
                    state_d = S_SHL_0;
                end
            end
            S_ADD_0: state_d = S_ADD_1;
            S_ADD_1: state_d = S_ADD_2;
            S_ADD_2: state_d = S_SHL_0;
            S_SHL_0: state_d = S_SHL_1;
            S_SHL_1: state_d = S_SHL_2;
            S_SHL_2: state_d = S_SHL_3;
            S_SHL_3: state_d = S_SHR_0;
            S_SHR_0: state_d = S_SHR_1;
            S_SHR_1: state_d = S_SHR_2;
            S_SHR_2: state_d = S_SHR_3;
            S_SHR_3: begin
                state_d = S_TEST;
                if (cnt_q != ITER_CNT) begin
                    cnt_d = cnt_q + DW_CNT'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (SC_SHIFTADD_SEQUENCER_Abort_InHigh && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // Moore microword decode: idle microword first, then per-state overrides.
    always_comb begin
        SC_SHIFTADD_SEQUENCER_DecoderSelectionWrite_Out      = DEC_NONE;
        SC_SHIFTADD_SEQUENCER_MUXSelectionBUSA_Out           = MUX_NONE;
        SC_SHIFTADD_SEQUENCER_MUXSelectionBUSB_Out           = MUX_NONE;
        SC_SHIFTADD_SEQUENCER_ALUSelection_Out               = ALU_IDLE;
        SC_SHIFTADD_SEQUENCER_RegSHIFTERLoad_OutLow          = 1'b1;
        SC_SHIFTADD_SEQUENCER_RegSHIFTERShiftSelection_OutLow = SH_HOLD;
        SC_SHIFTADD_SEQUENCER_Busy_Out                       = (state_q != S_IDLE);
        SC_SHIFTADD_SEQUENCER_Done_OutHigh                   = 1'b0;
        case (state_q)
            S_CLR_0, S_CLR_1: begin
                SC_SHIFTADD_SEQUENCER_MUXSelectionBUSA_Out = MUX_R0;
                SC_SHIFTADD_SEQUENCER_MUXSelectionBUSB_Out = MUX_R0;
                SC_SHIFTADD_SEQUENCER_ALUSelection_Out     = ALU_XOR;
                SC_SHIFTADD_SEQUENCER_RegSHIFTERLoad_OutLow = (state_q != S_CLR_1);
            end
            S_CLR_2, S_ADD_2: SC_SHIFTADD_SEQUENCER_DecoderSelectionWrite_Out = DEC_R0;
            S_TEST: begin
                SC_SHIFTADD_SEQUENCER_MUXSelectionBUSA_Out = MUX_R2;
                SC_SHIFTADD_SEQUENCER_ALUSelection_Out     = ALU_PASS_A;
            end
            S_ADD_0, S_ADD_1: begin
                SC_SHIFTADD_SEQUENCER_MUXSelectionBUSA_Out = MUX_R0;
                SC_SHIFTADD_SEQUENCER_MUXSelectionBUSB_Out = MUX_R1;
                SC_SHIFTADD_SEQUENCER_ALUSelection_Out     = ALU_ADD;
                SC_SHIFTADD_SEQUENCER_RegSHIFTERLoad_OutLow = (state_q != S_ADD_1);
            end
            S_SHL_0, S_SHL_1: begin
                SC_SHIFTADD_SEQUENCER_MUXSelectionBUSA_Out = MUX_R1;
                SC_SHIFTADD_SEQUENCER_ALUSelection_Out     = ALU_PASS_A;
                SC_SHIFTADD_SEQUENCER_RegSHIFTERLoad_OutLow = (state_q != S_SHL_1);
            end
            S_SHL_2: SC_SHIFTADD_SEQUENCER_RegSHIFTERShiftSelection_OutLow = SH_LEFT;
            S_SHL_3: SC_SHIFTADD_SEQUENCER_DecoderSelectionWrite_Out = DEC_R1;
            S_SHR_0, S_SHR_1: begin
                SC_SHIFTADD_SEQUENCER_MUXSelectionBUSA_Out = MUX_R2;
                SC_SHIFTADD_SEQUENCER_ALUSelection_Out     = ALU_PASS_A;
                SC_SHIFTADD_SEQUENCER_RegSHIFTERLoad_OutLow = (state_q != S_SHR_1);
            end
            S_SHR_2: SC_SHIFTADD_SEQUENCER_RegSHIFTERShiftSelection_OutLow = SH_RIGHT;
            S_SHR_3: SC_SHIFTADD_SEQUENCER_DecoderSelectionWrite_Out = DEC_R2;
            S_DONE:  SC_SHIFTADD_SEQUENCER_Done_OutHigh = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/sc_shiftadd_sequencer.md
SC_SHIFTADD_SEQUENCER -- requirements
Module: sc_shiftadd_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATAWIDTH_DECODER_SELECTION, 3, write-decoder select width
- DATAWIDTH_MUX_SELECTION, 3, BUSA/BUSB mux select width
- DATAWIDTH_ALU_SELECTION, 4, ALU op width
- DATAWIDTH_REGSHIFTER_SELECTION, 2, shifter select width
- ITERATIONS, 8, maximum multiplier bits processed
- DATAWIDTH_COUNT, 4, iteration counter width; must hold ITERATIONS
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- SC_SHIFTADD_SEQUENCER_CLOCK_50, in, 1, sole clock, rising edge
- SC_SHIFTADD_SEQUENCER_Reset_InLow, in, 1, asynchronous active-low reset
- SC_SHIFTADD_SEQUENCER_Start_InHigh, in, 1, start request, sampled in IDLE only
- SC_SHIFTADD_SEQUENCER_Abort_InHigh, in, 1, synchronous abort
- SC_SHIFTADD_SEQUENCER_Zero_InLow, in, 1, ALU zero flag, 0 = result zero
- SC_SHIFTADD_SEQUENCER_LSB_In, in, 1, bit 0 of the current ALU result
- SC_SHIFTADD_SEQUENCER_DecoderSelectionWrite_Out, out, DECODER width, write target; 111 = none
- SC_SHIFTADD_SEQUENCER_MUXSelectionBUSA_Out / _MUXSelectionBUSB_Out, out, MUX width, read selects; 000..011 = RegGEN0..3; 111 = none
- SC_SHIFTADD_SEQUENCER_ALUSelection_Out, out, ALU width, op select: 0000 A, 0100 XOR, 1000 ADD, 1111 idle
- SC_SHIFTADD_SEQUENCER_RegSHIFTERLoad_OutLow, out, 1, 0 = load shifter
- SC_SHIFTADD_SEQUENCER_RegSHIFTERShiftSelection_OutLow, out, 2, 01 = left, 10 = right, 11 = hold
- SC_SHIFTADD_SEQUENCER_Busy_Out, out, 1, high in every state except IDLE
- SC_SHIFTADD_SEQUENCER_Done_OutHigh, out, 1, one-cycle completion pulse
REQ-003 Reset SHALL be one clock; reset is asynchronous and active-low.

Function
REQ-004 Register roles SHALL be: RegGEN0 = product accumulator, RegGEN1 = multiplicand, RegGEN2 = multiplier, RegGEN3 untouched.
REQ-005 The idle microword SHALL be: decoder 111, BUSA 111, BUSB 111, ALU 1111, load 1, shift 11. Every state drives the idle microword except for the fields listed below.
REQ-006 The machine SHALL be a registered-state Moore FSM with these states: IDLE, CLR_0..2, TEST, ADD_0..2, SHL_0..3, SHR_0..3, DONE. All outputs are decoded combinationally from the state register.
REQ-007 IDLE SHALL go to CLR_0 when Start = 1; otherwise it stays in IDLE. The iteration counter is cleared on entry to CLR_0.
REQ-008 The clear sequence SHALL be:
- CLR_0: BUSA 000, BUSB 000, ALU 0100
- CLR_1: as CLR_0, plus load 0
- CLR_2: decoder 000
- Next state: TEST.
REQ-009 TEST SHALL drive BUSA 010 and ALU 0000, and sample Zero_InLow and LSB_In in the same cycle. Transitions:
- Zero_InLow = 0, or counter = ITERATIONS: go to DONE.
- Else LSB_In = 1: go to ADD_0.
- Else: go to SHL_0.
REQ-010 The add sequence SHALL be:
- ADD_0: BUSA 000, BUSB 001, ALU 1000
- ADD_1: as ADD_0, plus load 0
- ADD_2: decoder 000
- Next state: SHL_0.
REQ-011 The shift-left sequence SHALL be:
- SHL_0: BUSA 001, ALU 0000
- SHL_1: as SHL_0, plus load 0
- SHL_2: shift 01
- SHL_3: decoder 001
- Next state: SHR_0.
REQ-012 The shift-right sequence SHALL be:
- SHR_0 through SHR_3: as SHL, but BUSA 010, shift 10 and decoder 010.
- SHR_3 increments the counter; next state is TEST.
REQ-013 DONE SHALL assert Done_OutHigh for exactly one cycle, then go to IDLE. Busy_Out is low in IDLE and high in every other state.
REQ-014 Cycle counts SHALL be: clear 3, TEST 1, iteration 8 without add and 11 with add, DONE 1.
REQ-015 Start SHALL be ignored outside IDLE. Start held high after DONE starts a new run from IDLE on the next cycle.
REQ-016 Abort = 1 in any non-IDLE state SHALL force IDLE on the next edge with no Done pulse. Abort takes priority over all transitions; Abort in IDLE has no effect.
REQ-017 The counter SHALL saturate at ITERATIONS and never wrap. Unused state encodings return to IDLE with the idle microword.

Reset
REQ-018 While Reset_InLow = 0, the FSM SHALL be in IDLE with counter 0, idle microword, Busy 0 and Done 0, independent of the clock.
REQ-019 Reset asserted mid-operation SHALL abandon the run immediately with no Done pulse. After release, the block waits in IDLE for a new Start.

Verification
REQ-020 The bench SHALL cover these scenarios:
- RegGEN1 = 5, RegGEN2 = 3, Start pulsed with the sampling edge as cycle 0: ADD visited twice, TEST sees zero at cycle 28, Done high in cycle 29, RegGEN0 = 15.
- RegGEN2 = 0, Start: CLR cycles 1-3, TEST cycle 4, Done in cycle 5, no ADD/SHL/SHR states, RegGEN0 = 0.
- RegGEN1 = 1, RegGEN2 = 0xFF, ITERATIONS = 8: eight iterations with add, counter-limited exit, Done in cycle 101, RegGEN0 = 0xFF.
- Abort asserted during SHL_2: IDLE next cycle, Busy 0, no Done, idle microword; a following Start runs normally.
- Reset_InLow pulsed low between clock edges during ADD_1: outputs return to idle values immediately; Start pulses while Busy are ignored.
